// File: rtl/sha256_nonce_checker.sv
// sha256_nonce_checker: nonce sequencer and result checker for the sha256_transform pipeline.
// Issues one nonce every LOOP cycles, tracks it through a LATENCY-deep delay line, tests the
// returned hash for ZERO_BITS leading zeros and queues matching nonces in a small FIFO.
// Optional build macro: NONCE_CHECKER_STATS_EN (enables the saturating hash_count counter).
module sha256_nonce_checker #(
  parameter int unsigned LOOP       = 4,
  parameter int unsigned LATENCY    = 66,
  parameter int unsigned ZERO_BITS  = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  nonce_init,
  input  logic [31:0]  nonce_last,
  output logic [5:0]   cnt,
  output logic         feedback,
  output logic [31:0]  nonce,
  input  logic [255:0] hash_in,
  output logic [31:0]  golden_nonce,
  output logic         golden_valid,
  input  logic         golden_ready,
  output logic         overflow,
  output logic         busy,
  output logic         done,
  output logic [31:0]  hash_count
);

  localparam int unsigned NONCE_W = 32;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned FIFO_IW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FIFO_CW = FIFO_IW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [NONCE_W-1:0]   last_q;

  logic [LATENCY-1:0]   dl_valid;
  logic [NONCE_W-1:0]   dl_nonce [LATENCY];

  logic [NONCE_W-1:0]   fifo_q [FIFO_DEPTH];
  logic [FIFO_CW-1:0]   count_q;

  logic                 issue;
  logic                 last_issue;
  logic                 cnt_wrap;
  logic                 line_pending;
  logic                 tap_valid;
  logic                 tap_match;
  logic [NONCE_W-1:0]   tap_nonce;
  logic                 fifo_full;
  logic                 pop;
  logic                 push_ok;
  logic                 fifo_drop;
  logic [FIFO_IW-1:0]   wr_idx;
  logic [FIFO_CW-1:0]   count_nxt;
  logic                 unused_hash_lsbs;

  // Issue/tap decode shared by the sequencer, delay line and FIFO
  always_comb begin
    issue        = (state == S_RUN) && (cnt == '0);
    last_issue   = issue && (nonce >= last_q);
    cnt_wrap     = (cnt == CNT_W'(LOOP - 1));
    line_pending = |dl_valid[LATENCY-2:0];
    // A restart discards whatever sits at the tap in the same cycle
    tap_valid    = dl_valid[LATENCY-1] && !start;
    tap_nonce    = dl_nonce[LATENCY-1];
    tap_match    = tap_valid && (hash_in[255 -: ZERO_BITS] == '0);
    fifo_full    = (count_q == FIFO_CW'(FIFO_DEPTH));
    pop          = golden_valid && golden_ready;
    push_ok      = tap_match && (!fifo_full || pop);
    fifo_drop    = tap_match && fifo_full && !pop;
    wr_idx       = pop ? FIFO_IW'(count_q - FIFO_CW'(1)) : FIFO_IW'(count_q);
    count_nxt    = count_q + FIFO_CW'(push_ok) - FIFO_CW'(pop);
  end

  // Only the leading ZERO_BITS of the hash matter to the difficulty test
  assign unused_hash_lsbs = ^hash_in[255-ZERO_BITS:0];

  // Sequencer FSM: nonce/cnt/feedback generation and busy/done status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      feedback <= 1'b1;
      nonce    <= '0;
      last_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      state    <= S_RUN;
      cnt      <= '0;
      feedback <= 1'b0;
      nonce    <= nonce_init;
      last_q   <= nonce_last;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (last_issue) begin
            // Final nonce goes out this cycle; nonce holds so the range never wraps
            state    <= S_DRAIN;
            cnt      <= '0;
            feedback <= 1'b1;
          end else begin
            cnt      <= cnt_wrap ? '0 : cnt + CNT_W'(1);
            feedback <= !cnt_wrap;
            if (issue) begin
              nonce <= nonce + NONCE_W'(1);
            end
          end
        end
        S_DRAIN: begin
          // Whatever is at the tap now leaves this edge; nothing behind it means empty
          if (!line_pending) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          cnt      <= '0;
          feedback <= 1'b1;
        end
      endcase
    end
  end

  // Delay line tracking each issued nonce to the cycle its hash returns
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_valid <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        dl_nonce[i] <= '0;
      end
    end else begin
      if (start) begin
        dl_valid <= '0;
      end else begin
        dl_valid <= {dl_valid[LATENCY-2:0], issue};
      end
      dl_nonce[0] <= nonce;
      for (int i = 1; i < int'(LATENCY); i++) begin
        dl_nonce[i] <= dl_nonce[i-1];
      end
    end
  end

  // Golden-nonce FIFO as a shift queue so the head is always a flop output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
      count_q      <= '0;
      golden_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (pop) begin
        for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
          fifo_q[i] <= fifo_q[i+1];
        end
      end
      if (push_ok) begin
        fifo_q[wr_idx] <= tap_nonce;
      end
      count_q      <= count_nxt;
      golden_valid <= (count_nxt != '0);
      if (start) begin
        overflow <= 1'b0;
      end else if (fifo_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign golden_nonce = fifo_q[0];

`ifdef NONCE_CHECKER_STATS_EN
  // Saturating count of hashes checked since the last start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hash_count <= '0;
    end else if (start) begin
      hash_count <= '0;
    end else if (tap_valid && (hash_count != '1)) begin
      hash_count <= hash_count + 32'd1;
    end
  end
`else
  assign hash_count = '0;
`endif

endmodule

// File: tb/tb_sha256_nonce_checker.sv
// Directed bench for sha256_nonce_checker: models the transform as a LATENCY-deep pipe that
// returns a chosen hash pattern per nonce, and checks sequencing, matching, FIFO and status.
module tb_sha256_nonce_checker;

  localparam int unsigned LOOP = 4;
  localparam int unsigned LAT  = 66;
  localparam int unsigned ZB   = 32;
  localparam int unsigned FD   = 4;

`ifdef NONCE_CHECKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic [31:0]  nonce_init;
  logic [31:0]  nonce_last;
  logic [5:0]   cnt;
  logic         feedback;
  logic [31:0]  nonce;
  logic [255:0] hash_in;
  logic [31:0]  golden_nonce;
  logic         golden_valid;
  logic         golden_ready;
  logic         overflow;
  logic         busy;
  logic         done;
  logic [31:0]  hash_count;

  int pass_cnt;
  int total_cnt;
  int mode;
  logic [32:0] hist [LAT];

  sha256_nonce_checker #(
    .LOOP(LOOP), .LATENCY(LAT), .ZERO_BITS(ZB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .nonce_init(nonce_init), .nonce_last(nonce_last),
    .cnt(cnt), .feedback(feedback), .nonce(nonce),
    .hash_in(hash_in),
    .golden_nonce(golden_nonce), .golden_valid(golden_valid), .golden_ready(golden_ready),
    .overflow(overflow), .busy(busy), .done(done), .hash_count(hash_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transform model: remembers what was offered on each new-input cycle
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(LAT); i++) hist[i] <= '0;
    end else begin
      hist[0] <= {~feedback, nonce};
      for (int i = 1; i < int'(LAT); i++) hist[i] <= hist[i-1];
    end
  end

  // Hash pattern chosen per test: 1 = only 0x12 matches, 2 = all match,
  // 3 = zero hash every cycle, 4 = difficulty boundary for 0x20/0x21
  function automatic logic [255:0] model_hash(input int m, input logic [31:0] n);
    logic [255:0] h;
    case (m)
      1: h = (n == 32'h12) ? '0 : '1;
      2: h = '0;
      4: h = (n == 32'h20) ? {32'h0, {224{1'b1}}} : {31'h0, 1'b1, 224'h0};
      default: h = '1;
    endcase
    return h;
  endfunction

  always_comb begin
    hash_in = '1;
    if (mode == 3) hash_in = '0;
    else if (hist[LAT-1][32] === 1'b1) hash_in = model_hash(mode, hist[LAT-1][31:0]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_start(input logic [31:0] first, input logic [31:0] last);
    nonce_init = first;
    nonce_last = last;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check(tag, done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pass_cnt = 0; total_cnt = 0; mode = 0;
    reset = 1'b1; start = 1'b0; nonce_init = '0; nonce_last = '0; golden_ready = 1'b0;
    repeat (3) tick();
    check("rst_cnt", cnt, 6'd0);
    check("rst_feedback", feedback, 1'b1);
    check("rst_nonce", nonce, 32'h0);
    check("rst_gvalid", golden_valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hash_count", hash_count, 32'h0);
    reset = 1'b0;

    // Zero hash with no valid taps must never push
    mode = 3;
    repeat (5) tick();
    check("idle_zero_hash_gvalid", golden_valid, 1'b0);
    check("idle_feedback", feedback, 1'b1);
    mode = 1;
    tick();

    // Basic range 0x10..0x13, only 0x12 golden
    do_start(32'h10, 32'h13);
    for (int c = 0; c <= 79; c++) begin
      if (c <= 12) begin
        check("A_feedback", feedback, 1'((c % 4) != 0));
        check("A_cnt", cnt, 6'(c % 4));
        if (c % 4 == 0) check("A_nonce", nonce, 32'h10 + 32'(c / 4));
      end
      if (c == 13) check("A_drain_feedback", feedback, 1'b1);
      if (c == 74) check("A_gvalid_before", golden_valid, 1'b0);
      if (c == 75) begin
        check("A_gvalid_after", golden_valid, 1'b1);
        check("A_golden", golden_nonce, 32'h12);
      end
      if (c == 78) begin
        check("A_done_early", done, 1'b0);
        check("A_busy_drain", busy, 1'b1);
      end
      if (c == 79) begin
        check("A_done", done, 1'b1);
        check("A_busy_end", busy, 1'b0);
        check("A_only_one", golden_nonce, 32'h12);
        check("A_hash_count", hash_count, STATS ? 32'd4 : 32'd0);
      end
      if (c != 79) tick();
    end
    golden_ready = 1'b1;
    tick();
    golden_ready = 1'b0;
    check("A_pop_empty", golden_valid, 1'b0);
    check("A_overflow", overflow, 1'b0);

    // Difficulty boundary: bit 223 set passes, bit 224 set fails
    mode = 4;
    do_start(32'h20, 32'h21);
    wait_done("B_done");
    check("B_gvalid", golden_valid, 1'b1);
    check("B_golden", golden_nonce, 32'h20);
    golden_ready = 1'b1;
    tick();
    golden_ready = 1'b0;
    check("B_bit224_no_push", golden_valid, 1'b0);

    // Overflow: six matches into a four-deep FIFO with no consumer
    mode = 2;
    do_start(32'h30, 32'h35);
    wait_done("C_done");
    check("C_overflow", overflow, 1'b1);
    check("C_gvalid", golden_valid, 1'b1);
    check("C_head", golden_nonce, 32'h30);
    repeat (2) tick();
    check("C_head_stable", golden_nonce, 32'h30);
    golden_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("C_pop_valid", golden_valid, 1'b1);
      check("C_pop_order", golden_nonce, 32'h30 + 32'(i));
      tick();
    end
    golden_ready = 1'b0;
    check("C_empty", golden_valid, 1'b0);
    check("C_overflow_sticky", overflow, 1'b1);

    // Restart with nonces in flight: they are discarded, FIFO contents kept
    do_start(32'h40, 32'h40);
    check("D_overflow_cleared", overflow, 1'b0);
    check("D_done_cleared", done, 1'b0);
    wait_done("D_done_first");
    check("D_first_head", golden_nonce, 32'h40);
    do_start(32'h50, 32'h5F);
    repeat (9) tick();
    do_start(32'h60, 32'h60);
    wait_done("D_done_second");
    check("D_head_kept", golden_nonce, 32'h40);
    golden_ready = 1'b1;
    tick();
    check("D_second", golden_nonce, 32'h60);
    check("D_second_valid", golden_valid, 1'b1);
    tick();
    golden_ready = 1'b0;
    check("D_no_inflight_push", golden_valid, 1'b0);

    // nonce_init above nonce_last: issue nonce_init only
    do_start(32'h80, 32'h7F);
    check("E_issue_fb", feedback, 1'b0);
    check("E_issue_nonce", nonce, 32'h80);
    tick();
    check("E_drain_fb", feedback, 1'b1);
    check("E_drain_nonce", nonce, 32'h80);
    wait_done("E_done");
    check("E_golden", golden_nonce, 32'h80);
    golden_ready = 1'b1;
    tick();
    golden_ready = 1'b0;
    check("E_single", golden_valid, 1'b0);

    // Top of the nonce space: no wrap, two hashes checked
    mode = 0;
    do_start(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    check("F_first", nonce, 32'hFFFF_FFFE);
    repeat (4) tick();
    check("F_last_fb", feedback, 1'b0);
    check("F_last", nonce, 32'hFFFF_FFFF);
    tick();
    check("F_no_wrap_drain", nonce, 32'hFFFF_FFFF);
    wait_done("F_done");
    check("F_no_wrap_done", nonce, 32'hFFFF_FFFF);
    check("F_hash_count", hash_count, STATS ? 32'd2 : 32'd0);
    check("F_no_golden", golden_valid, 1'b0);

    // Reset in the middle of a run with entries queued
    mode = 2;
    do_start(32'h100, 32'h1FF);
    repeat (70) tick();
    check("G_pre_gvalid", golden_valid, 1'b1);
    check("G_pre_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    check("G_cnt", cnt, 6'd0);
    check("G_feedback", feedback, 1'b1);
    check("G_nonce", nonce, 32'h0);
    check("G_gvalid", golden_valid, 1'b0);
    check("G_busy", busy, 1'b0);
    check("G_done", done, 1'b0);
    check("G_overflow", overflow, 1'b0);
    check("G_hash_count", hash_count, 32'h0);
    reset = 1'b0;
    repeat (3) tick();
    check("G_idle_feedback", feedback, 1'b1);
    check("G_idle_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
